// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin resource arbiter.
package arb_pkg;

   typedef enum logic {ARB, LOCK} arb_state_t;

   // Width of a counter that must represent 0..max_hold inclusive.
   function automatic int unsigned cnt_width(input int unsigned max_hold);
      return $clog2(max_hold + 1);
   endfunction

endpackage

// File: rtl/onehot_to_binary.sv
// One-hot to binary encoder; an all-zero input encodes to 0.
module onehot_to_binary #(
   parameter int unsigned N     = 8,
   parameter int unsigned IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     i_oh,
   output logic [IDX_W-1:0] o_bin
);

   always_comb begin
      o_bin = '0;
      for (int i = 0; i < N; i++) begin
         if (i_oh[i]) begin
            o_bin = o_bin | IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate by ptr, find first set bit, rotate back.
module rr_pick
   import arb_pkg::*;
#(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0]         i_req,
   input  logic [$clog2(N)-1:0] i_ptr,
   input  logic [N-1:0]         i_mask,
   output logic [N-1:0]         o_pick
);

   localparam int unsigned IDX_W = $clog2(N);

   logic [N-1:0] w_req_m;
   logic [N-1:0] w_rot;
   logic [N-1:0] w_first;

   assign w_req_m = i_req & ~i_mask;
   // Isolate the lowest set bit of the rotated vector.
   assign w_first = w_rot & (~w_rot + N'(1));

   always_comb begin
      w_rot  = '0;
      o_pick = '0;
      for (int i = 0; i < N; i++) begin
         w_rot[i] = w_req_m[IDX_W'(i) + i_ptr];
      end
      for (int i = 0; i < N; i++) begin
         o_pick[IDX_W'(i) + i_ptr] = w_first[i];
      end
   end

endmodule

// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter for one shared resource with hold-based multi-cycle
// ownership and a bounded lock that forces release after MAX_HOLD cycles.
module rr_resource_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned N        = 8,
   parameter int unsigned MAX_HOLD = 4,
   parameter int unsigned IDX_W    = $clog2(N)
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic [N-1:0]     i_req,
   input  logic [N-1:0]     i_hold,
   input  logic             i_res_ready,
   output logic [N-1:0]     o_gnt_oh,
   output logic [IDX_W-1:0] o_gnt_idx,
   output logic             o_gnt_valid,
   output logic             o_locked,
   output logic             o_timeout
);

   localparam int unsigned       CNT_W   = cnt_width(MAX_HOLD);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HOLD);

   arb_state_t       r_state, w_state_d;
   logic [N-1:0]     r_gnt_oh, w_gnt_oh_d;
   logic [IDX_W-1:0] r_ptr, w_ptr_d;
   logic [CNT_W-1:0] r_hold_cnt, w_hold_cnt_d;
   logic             r_timeout, w_timeout_d;

   logic [N-1:0]     w_mask;
   logic [N-1:0]     w_pick;
   logic [IDX_W-1:0] w_pick_idx;
   logic             w_own_keep;
   logic             w_force;

   assign w_own_keep = (r_state == LOCK) && |(i_req & r_gnt_oh) && |(i_hold & r_gnt_oh);
   assign w_force    = w_own_keep && (r_hold_cnt == MAX_CNT);
   // A forced release must not hand the resource straight back to the owner.
   assign w_mask     = w_force ? r_gnt_oh : '0;

   rr_pick #(
      .N (N)
   ) u_pick (
      .i_req  (i_req),
      .i_ptr  (r_ptr),
      .i_mask (w_mask),
      .o_pick (w_pick)
   );

   onehot_to_binary #(
      .N     (N),
      .IDX_W (IDX_W)
   ) u_pick_enc (
      .i_oh  (w_pick),
      .o_bin (w_pick_idx)
   );

   always_comb begin
      w_state_d    = r_state;
      w_gnt_oh_d   = r_gnt_oh;
      w_ptr_d      = r_ptr;
      w_hold_cnt_d = r_hold_cnt;
      w_timeout_d  = 1'b0;
      if (w_own_keep && !w_force) begin
         w_hold_cnt_d = r_hold_cnt + CNT_W'(1);
      end else begin
         w_timeout_d = w_force;
         if (i_res_ready && |w_pick) begin
            w_gnt_oh_d   = w_pick;
            w_ptr_d      = w_pick_idx + IDX_W'(1);
            w_hold_cnt_d = CNT_W'(1);
            w_state_d    = |(i_hold & w_pick) ? LOCK : ARB;
         end else begin
            w_gnt_oh_d = '0;
            w_state_d  = ARB;
         end
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= ARB;
         r_gnt_oh   <= '0;
         r_ptr      <= '0;
         r_hold_cnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_gnt_oh   <= w_gnt_oh_d;
         r_ptr      <= w_ptr_d;
         r_hold_cnt <= w_hold_cnt_d;
         r_timeout  <= w_timeout_d;
      end
   end

   onehot_to_binary #(
      .N     (N),
      .IDX_W (IDX_W)
   ) u_gnt_enc (
      .i_oh  (r_gnt_oh),
      .o_bin (o_gnt_idx)
   );

   assign o_gnt_oh    = r_gnt_oh;
   assign o_gnt_valid = |r_gnt_oh;
   assign o_locked    = (r_state == LOCK);
   assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_rr_resource_arbiter.sv
// Directed bench for rr_resource_arbiter (N=8, MAX_HOLD=4).
module tb_rr_resource_arbiter;

   logic       r_clock = 1'b0;
   logic       r_reset;
   logic [7:0] r_req;
   logic [7:0] r_hold;
   logic       r_res_ready;
   logic [7:0] w_gnt_oh;
   logic [2:0] w_gnt_idx;
   logic       w_gnt_valid;
   logic       w_locked;
   logic       w_timeout;

   int n_checks = 0;
   int n_pass   = 0;

   rr_resource_arbiter #(
      .N        (8),
      .MAX_HOLD (4)
   ) dut (
      .i_clock     (r_clock),
      .i_reset     (r_reset),
      .i_req       (r_req),
      .i_hold      (r_hold),
      .i_res_ready (r_res_ready),
      .o_gnt_oh    (w_gnt_oh),
      .o_gnt_idx   (w_gnt_idx),
      .o_gnt_valid (w_gnt_valid),
      .o_locked    (w_locked),
      .o_timeout   (w_timeout)
   );

   always #5 r_clock = ~r_clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_grant(input string tag, input logic v, input int idx,
                               input logic lk, input logic to);
      logic [7:0] oh;
      oh = v ? (8'h01 << idx) : 8'h00;
      check({tag, ".valid"}, 32'(w_gnt_valid), 32'(v));
      check({tag, ".oh"}, 32'(w_gnt_oh), 32'(oh));
      check({tag, ".idx"}, 32'(w_gnt_idx), v ? 32'(idx) : 32'd0);
      check({tag, ".locked"}, 32'(w_locked), 32'(lk));
      check({tag, ".timeout"}, 32'(w_timeout), 32'(to));
   endtask

   task automatic tick();
      @(posedge r_clock);
      #1;
   endtask

   initial begin
      int rr_exp [6] = '{2, 5, 7, 2, 5, 7};

      r_reset     = 1'b1;
      r_req       = 8'h00;
      r_hold      = 8'h00;
      r_res_ready = 1'b1;
      #2;
      expect_grant("reset", 1'b0, 0, 1'b0, 1'b0);
      #10;
      r_reset = 1'b0;

      // Round robin over 2,5,7 starting from ptr=0.
      r_req = 8'b1010_0100;
      for (int i = 0; i < 6; i++) begin
         tick();
         expect_grant($sformatf("rr%0d", i), 1'b1, rr_exp[i], 1'b0, 1'b0);
      end

      // Lone requester 7; ptr wraps to 0 after each grant.
      r_req = 8'h80;
      for (int i = 0; i < 4; i++) begin
         tick();
         expect_grant($sformatf("lone%0d", i), 1'b1, 7, 1'b0, 1'b0);
      end

      // Backpressure: no grants, ptr stays at 0, then 1 then 2.
      r_req       = 8'h06;
      r_res_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_grant($sformatf("bp%0d", i), 1'b0, 0, 1'b0, 1'b0);
      end
      r_res_ready = 1'b1;
      tick();
      expect_grant("bp_a", 1'b1, 1, 1'b0, 1'b0);
      tick();
      expect_grant("bp_b", 1'b1, 2, 1'b0, 1'b0);

      // Lock on 3 (ptr=3) for 3 cycles, res_ready toggled mid-lock, then release to 1.
      r_req  = 8'h0A;
      r_hold = 8'h08;
      tick();
      expect_grant("lock0", 1'b1, 3, 1'b1, 1'b0);
      tick();
      expect_grant("lock1", 1'b1, 3, 1'b1, 1'b0);
      r_res_ready = 1'b0;
      tick();
      expect_grant("lock2", 1'b1, 3, 1'b1, 1'b0);
      r_res_ready = 1'b1;
      r_hold      = 8'h00;
      tick();
      expect_grant("unlock", 1'b1, 1, 1'b0, 1'b0);

      // Timeout: ptr=2, owner 3 holds forever; forced release to 0 after 4 cycles.
      r_req  = 8'h09;
      r_hold = 8'h08;
      for (int i = 0; i < 4; i++) begin
         tick();
         expect_grant($sformatf("to_hold%0d", i), 1'b1, 3, 1'b1, 1'b0);
      end
      tick();
      expect_grant("to_force", 1'b1, 0, 1'b0, 1'b1);
      tick();
      expect_grant("to_regrant", 1'b1, 3, 1'b1, 1'b0);

      // Asynchronous reset in the middle of a lock, away from any clock edge.
      #2;
      r_reset = 1'b1;
      #1;
      expect_grant("async_rst", 1'b0, 0, 1'b0, 1'b0);
      #2;
      r_reset = 1'b0;
      r_req   = 8'h01;
      r_hold  = 8'h00;
      tick();
      expect_grant("post_rst", 1'b1, 0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
